calc_accumulator_p: RTL
=======================

# calc_accumulator_p

Parametrised, handshaked accumulator-calculator: the next generation of the team's 3-bit-in / 8-bit-out calculator. Each accepted operand is applied to a running accumulator with one of four operations: add, subtract, multiply or clear. Multiply is a multi-cycle shift-add sequence. Saturating or wrapping arithmetic is selectable, and a sticky overflow flag is kept. It sits between an operand source (testbench or keypad decoder) and a display/readout stage.

## Interface
- IN_W, 3, operand width; legal range IN_W >= 1
- OUT_W, 8, accumulator width; legal range OUT_W >= IN_W
- SAT, 0, overflow mode: 1 = saturate, 0 = wrap (truncate to OUT_W bits)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  operand and op are presented
- in_ready  out  1  block can accept; equals (state == IDLE)
- in_data  in  IN_W  unsigned operand
- flag  in  2  op select: 00 add, 01 subtract, 10 multiply, 11 clear
- out  out  OUT_W  accumulator value, registered
- ovf  out  1  sticky overflow/borrow flag, registered
- done  out  1  one-cycle pulse, high in the cycle after `out` is updated

## Operation
- All arithmetic is unsigned.
- Transfer happens on a rising edge where in_valid && in_ready. No other edge samples in_data or flag.
- FSM states:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0.
- IDLE, accepted add: result = out + in_data.
  - If the carry out of OUT_W bits is set: ovf <= 1; out <= all-ones when SAT = 1, else the truncated sum.
- IDLE, accepted subtract: result = out - in_data.
  - If in_data > out (borrow): ovf <= 1; out <= 0 when SAT = 1, else the two's-complement wrap.
- IDLE, accepted clear: out <= 0 and ovf <= 0.
  - The operand is ignored.
- IDLE, accepted multiply: latch the operands and go to MUL.
  - mcand <= out, mplier <= in_data, prod <= 0, cnt <= 0.
  - out is unchanged.
- MUL, each edge:
  - If mplier[cnt] = 1: prod += mcand << cnt. prod is OUT_W+IN_W bits wide, so no internal loss.
  - Then cnt++.
- MUL, edge where cnt == IN_W-1:
  - Add the final partial product as above.
  - If the full product >= 2^OUT_W: ovf <= 1; out <= all-ones when SAT = 1, else the low OUT_W bits.
  - Otherwise out <= the product.
  - Go to IDLE.
- MUL ignores in_valid, in_data and flag entirely.
- ovf is cleared only by reset or a clear op. It is never cleared by a later in-range result.
- Multiply by 0 still takes the full IN_W cycles and yields out = 0.

## Timing
- Reset values, applied asynchronously: state = IDLE, out = 0, ovf = 0, done = 0, in_ready = 1, and internal cnt/prod/mcand/mplier = 0.
- Reset asserted mid-multiply aborts the multiply. out returns to 0, not to its pre-multiply value.
- Add, subtract and clear:
  - out and ovf update on the accept edge (1-cycle latency).
  - done = 1 for the following cycle.
  - in_ready stays 1, so back-to-back accepts every cycle are legal.
- Multiply:
  - Accept at edge E0.
  - in_ready = 0 from after E0 up to and including the cycle ending at edge E0+IN_W.
  - out updates at E0+IN_W.
  - done is high in the cycle after E0+IN_W.
  - in_ready returns to 1 in the cycle after E0+IN_W, and a new accept is possible at E0+IN_W+1.
- done pulses exactly once per accepted op, including clear. done is never high for two consecutive cycles during MUL.
- in_valid held high through a MUL is not an accept.
  - If still held when in_ready returns, that operand is accepted on the first IDLE edge.

## Test plan
- Reset: hold reset, with in_valid toggling randomly.
  - Required: out = 0, ovf = 0, done = 0, in_ready = 1.
  - Release reset, then add 5, 7, 3 on consecutive cycles: out = 5, 12, 15 with a done pulse per op and ovf = 0.
- Multiply (IN_W = 3, OUT_W = 8): from out = 12, multiply by 5.
  - Required: in_ready low for 3 cycles and out = 12 during them.
  - Required: out = 60 at the 3rd edge after accept, then a single done pulse.
  - Random in_valid/in_data/flag applied during MUL must have no effect.
- Add overflow: build out = 252 with add 6, mul 6, mul 7, then add 7.
  - SAT = 1: out = 255, ovf = 1.
  - SAT = 0: out = 3, ovf = 1.
  - Then add 1: ovf stays 1.
- Subtract borrow: from out = 3, subtract 5.
  - SAT = 1: out = 0. SAT = 0: out = 254. ovf = 1 in both modes.
  - Then clear: out = 0, ovf = 0, done pulses.
- Multiply overflow and abort: from out = 100, multiply by 7.
  - SAT = 1: out = 255, ovf = 1. SAT = 0: out = 188, ovf = 1.
  - Repeat, asserting reset asynchronously mid-cycle in MUL cycle 2: out = 0, ovf = 0, in_ready = 1 immediately. After release, add 4 gives out = 4.
- Parameter sweep: IN_W = 4, OUT_W = 12, SAT = 0, 2000 random ops.
  - Compare every cycle against a reference model for out, ovf, done and in_ready.
  - Check multiply latency = 4 edges.

Source files
------------

// File: rtl/calc_accumulator_p.sv
// Handshaked accumulator: add, subtract, shift-add multiply, clear.
// Sticky overflow, with saturating or wrapping results.
module calc_accumulator_p #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       flag,
  output logic [OUT_W-1:0] out,
  output logic             ovf,
  output logic             done
);

  localparam int PW = OUT_W + IN_W;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [OUT_W-1:0] mcand_q, mcand_d;
  logic [IN_W-1:0]  mplier_q, mplier_d;

  logic             accept;
  logic [OUT_W:0]   sum;
  logic [OUT_W-1:0] diff;
  logic             borrow;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    prod_n;
  logic             hi_ovf;

  assign accept = in_valid && (state_q == IDLE);
  assign sum    = {1'b0, out_q} + (OUT_W+1)'(in_data);
  assign diff   = out_q - OUT_W'(in_data);
  assign borrow = OUT_W'(in_data) > out_q;

  // prod is wide enough that no partial product is ever lost
  assign pp     = mplier_q[cnt_q]
                ? ({{IN_W{1'b0}}, mcand_q} << cnt_q)
                : '0;
  assign prod_n = prod_q + pp;
  assign hi_ovf = |prod_n[PW-1:OUT_W];

  assign in_ready = (state_q == IDLE);
  assign out      = out_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (flag)
            2'b00: begin
              done_d = 1'b1;
              out_d  = sum[OUT_W-1:0];
              if (sum[OUT_W]) begin
                ovf_d = 1'b1;
                if (SAT) out_d = '1;
              end
            end
            2'b01: begin
              done_d = 1'b1;
              out_d  = diff;
              if (borrow) begin
                ovf_d = 1'b1;
                if (SAT) out_d = '0;
              end
            end
            2'b10: begin
              mcand_d  = out_q;
              mplier_d = in_data;
              prod_d   = '0;
              cnt_d    = '0;
              state_d  = MUL;
            end
            2'b11: begin
              done_d = 1'b1;
              out_d  = '0;
              ovf_d  = 1'b0;
            end
          endcase
        end
      end
      MUL: begin
        prod_d = prod_n;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
          out_d   = prod_n[OUT_W-1:0];
          if (hi_ovf) begin
            ovf_d = 1'b1;
            if (SAT) out_d = '1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule
